// File: rtl/i2c_encoder.sv
// I2C master driven by an ASCII command stream: 'S' start, hex pairs send a byte, 'P' stop.
// Each byte sent returns one response char ('A' ack / 'N' nack); commands are fetched only between bus phases.
module i2c_encoder #(
  parameter int P_QTR_DIV = 60
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_empty,
  output logic       o_ren,
  input  logic [7:0] i_rdata,
  input  logic       i_i2c_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  output logic       o_wen,
  output logic [7:0] o_wdata,
  output logic       o_busy
);

  localparam int CW = (P_QTR_DIV > 1) ? $clog2(P_QTR_DIV) : 1;

  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_P = 8'h50;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_N = 8'h4E;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, START, RSTART, BIT, ACK, STOP} state_t;

  state_t        state;
  logic [CW-1:0] qcnt;
  logic [1:0]    qtr;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [3:0]    nib_hi;
  logic          nib_vld;
  logic          bus_idle;
  logic          ack_smp;
  logic          sda_s1;
  logic          sda_s2;
  logic          qtr_end;
  logic          is_hex;
  logic          is_ws;
  logic [3:0]    hex_val;

  assign qtr_end = (qcnt == CW'(P_QTR_DIV - 1));
  assign is_ws   = (i_rdata == 8'h20) || (i_rdata == 8'h0D) || (i_rdata == 8'h0A);

  always_comb begin
    is_hex  = 1'b1;
    hex_val = 4'h0;
    if (i_rdata >= 8'h30 && i_rdata <= 8'h39)      hex_val = 4'(i_rdata - 8'h30);
    else if (i_rdata >= 8'h41 && i_rdata <= 8'h46) hex_val = 4'(i_rdata - 8'h37);
    else if (i_rdata >= 8'h61 && i_rdata <= 8'h66) hex_val = 4'(i_rdata - 8'h57);
    else                                           is_hex  = 1'b0;
  end

  // {scl_oe, sda_oe} for quarter q of a bus phase; b is the data bit in BIT.
  function automatic logic [1:0] drv(input state_t st, input logic [1:0] q, input logic b);
    logic [1:0] r;
    r = 2'b10;
    case (st)
      START: begin
        if (q == 2'd0)      r = 2'b00;
        else if (q == 2'd3) r = 2'b11;
        else                r = 2'b01;
      end
      RSTART: begin
        case (q)
          2'd0:    r = 2'b10;
          2'd1:    r = 2'b00;
          2'd2:    r = 2'b01;
          default: r = 2'b11;
        endcase
      end
      BIT:  r = {~q[1], ~b};
      ACK:  r = {~q[1], 1'b0};
      STOP: begin
        if (q == 2'd0)      r = 2'b11;
        else if (q == 2'd1) r = 2'b01;
        else                r = 2'b00;
      end
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      state    <= IDLE;
      o_ren    <= 1'b0;
      o_scl_oe <= 1'b0;
      o_sda_oe <= 1'b0;
      o_wen    <= 1'b0;
      o_wdata  <= 8'h00;
      o_busy   <= 1'b0;
      bus_idle <= 1'b1;
      nib_vld  <= 1'b0;
      nib_hi   <= 4'h0;
      qcnt     <= '0;
      qtr      <= 2'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      ack_smp  <= 1'b0;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
    end else begin
      sda_s1 <= i_i2c_sda;
      sda_s2 <= sda_s1;
      o_ren  <= 1'b0;
      o_wen  <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_empty) begin
            o_ren <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          state  <= DECODE;
          o_busy <= 1'b1;
        end
        DECODE: begin
          state   <= IDLE;
          o_busy  <= 1'b0;
          qcnt    <= '0;
          qtr     <= 2'd0;
          bit_idx <= 3'd0;
          if (i_rdata == CH_S) begin
            nib_vld <= 1'b0;
            o_busy  <= 1'b1;
            if (bus_idle) begin
              state                  <= START;
              {o_scl_oe, o_sda_oe}   <= drv(START, 2'd0, 1'b0);
            end else begin
              state                  <= RSTART;
              {o_scl_oe, o_sda_oe}   <= drv(RSTART, 2'd0, 1'b0);
            end
          end else if (i_rdata == CH_P) begin
            nib_vld <= 1'b0;
            if (!bus_idle) begin
              state                <= STOP;
              o_busy               <= 1'b1;
              {o_scl_oe, o_sda_oe} <= drv(STOP, 2'd0, 1'b0);
            end
          end else if (is_hex) begin
            if (!nib_vld) begin
              nib_hi  <= hex_val;
              nib_vld <= 1'b1;
            end else begin
              nib_vld <= 1'b0;
              // A byte completed with no START in effect is dropped silently.
              if (!bus_idle) begin
                shreg                <= {nib_hi, hex_val};
                state                <= BIT;
                o_busy               <= 1'b1;
                {o_scl_oe, o_sda_oe} <= drv(BIT, 2'd0, nib_hi[3]);
              end
            end
          end else if (!is_ws) begin
            nib_vld <= 1'b0;
          end
        end
        default: begin
          if (!qtr_end) begin
            qcnt <= qcnt + CW'(1);
          end else begin
            qcnt <= '0;
            qtr  <= qtr + 2'd1;
            if (state == ACK && qtr == 2'd2) ack_smp <= sda_s2;
            if (qtr != 2'd3) begin
              {o_scl_oe, o_sda_oe} <= drv(state, qtr + 2'd1, shreg[7]);
            end else begin
              case (state)
                BIT: begin
                  if (bit_idx == 3'd7) begin
                    state                <= ACK;
                    {o_scl_oe, o_sda_oe} <= drv(ACK, 2'd0, 1'b0);
                  end else begin
                    bit_idx              <= bit_idx + 3'd1;
                    shreg                <= {shreg[6:0], 1'b0};
                    {o_scl_oe, o_sda_oe} <= drv(BIT, 2'd0, shreg[6]);
                  end
                end
                ACK: begin
                  state                <= IDLE;
                  o_busy               <= 1'b0;
                  o_wen                <= 1'b1;
                  o_wdata              <= ack_smp ? CH_N : CH_A;
                  {o_scl_oe, o_sda_oe} <= 2'b10;
                end
                STOP: begin
                  state                <= IDLE;
                  o_busy               <= 1'b0;
                  bus_idle             <= 1'b1;
                  {o_scl_oe, o_sda_oe} <= 2'b00;
                end
                default: begin
                  // START / RSTART end with SCL and SDA both held low.
                  state    <= IDLE;
                  o_busy   <= 1'b0;
                  bus_idle <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_encoder.sv
// Scoreboard bench: command strings feed a FIFO model; a bus decoder + slave checks bytes, timing and responses.
module tb_i2c_encoder;

  localparam int QD       = 4;
  localparam int EV_START = 32'h100;
  localparam int EV_STOP  = 32'h200;

  typedef logic [7:0] cq_t[$];

  logic       i_clk;
  logic       i_res;
  logic       i_empty;
  logic       o_ren;
  logic [7:0] i_rdata;
  logic       i_i2c_sda;
  logic       o_scl_oe;
  logic       o_sda_oe;
  logic       o_wen;
  logic [7:0] o_wdata;
  logic       o_busy;

  logic       slave_pull;
  int         n_cmp;
  int         n_fail;
  int         exp_ev[$];
  logic [7:0] exp_rsp[$];
  logic [7:0] fifo[$];
  int         scl_edges;
  int         n_wen;
  int         bitcnt;
  int         cyc;
  int         last_rise;
  logic [7:0] shv;
  logic       first_b;
  logic       addr_ok;
  logic       scl_p;
  logic       sda_p;

  // Open-drain SDA: low if either the master or the slave model pulls.
  assign i_i2c_sda = ~o_sda_oe & ~slave_pull;

  i2c_encoder #(.P_QTR_DIV(QD)) dut (
    .i_clk     (i_clk),
    .i_res     (i_res),
    .i_empty   (i_empty),
    .o_ren     (o_ren),
    .i_rdata   (i_rdata),
    .i_i2c_sda (i_i2c_sda),
    .o_scl_oe  (o_scl_oe),
    .o_sda_oe  (o_sda_oe),
    .o_wen     (o_wen),
    .o_wdata   (o_wdata),
    .o_busy    (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input int got);
    int e;
    if (exp_ev.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bus_event: got 0x%0h, expected none", got);
    end else begin
      e = exp_ev.pop_front();
      check("bus_event", got, e);
    end
  endtask

  // Reference model: walks the command characters and lists bus events and responses.
  task automatic model(input cq_t cmd);
    bit         act   = 1'b0;
    bit         pend  = 1'b0;
    bit         first = 1'b0;
    bit         aok   = 1'b0;
    bit         ok;
    bit         hex;
    logic [3:0] hi = 4'h0;
    logic [3:0] v;
    logic [7:0] c;
    logic [7:0] b;
    for (int i = 0; i < cmd.size(); i++) begin
      c   = cmd[i];
      hex = 1'b1;
      v   = 4'h0;
      if (c >= 8'h30 && c <= 8'h39)      v = 4'(c - 8'h30);
      else if (c >= 8'h41 && c <= 8'h46) v = 4'(c - 8'h37);
      else if (c >= 8'h61 && c <= 8'h66) v = 4'(c - 8'h57);
      else                               hex = 1'b0;
      if (c == 8'h53) begin
        pend  = 1'b0;
        act   = 1'b1;
        first = 1'b1;
        exp_ev.push_back(EV_START);
      end else if (c == 8'h50) begin
        pend = 1'b0;
        if (act) exp_ev.push_back(EV_STOP);
        act = 1'b0;
      end else if (hex) begin
        if (!pend) begin
          hi   = v;
          pend = 1'b1;
        end else begin
          pend = 1'b0;
          if (act) begin
            b = {hi, v};
            exp_ev.push_back(int'(b));
            ok = first ? (b == 8'hA0) : aok;
            if (first) aok = ok;
            first = 1'b0;
            exp_rsp.push_back(ok ? 8'h41 : 8'h4E);
          end
        end
      end else if (!(c == 8'h20 || c == 8'h0D || c == 8'h0A)) begin
        pend = 1'b0;
      end
    end
  endtask

  function automatic cq_t s2q(input string s);
    cq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic cq_t rnd_cmd();
    cq_t   q;
    string al;
    int    n;
    int    k;
    al = "0123456789ABCDEFabcdef";
    if ($urandom_range(0, 3) != 0) q.push_back(8'h53);
    n = $urandom_range(2, 6);
    for (int t = 0; t < n; t++) begin
      case ($urandom_range(0, 5))
        0: q.push_back(8'h53);
        1: begin q.push_back(8'h41); q.push_back(8'h30); end
        2, 3: begin
          k = $urandom_range(0, 21); q.push_back(al[k]);
          k = $urandom_range(0, 21); q.push_back(al[k]);
        end
        4: begin
          case ($urandom_range(0, 4))
            0: q.push_back(8'h20);
            1: q.push_back(8'h0D);
            2: q.push_back(8'h0A);
            3: q.push_back(8'h5A);
            default: q.push_back(8'h2E);
          endcase
        end
        default: begin k = $urandom_range(0, 21); q.push_back(al[k]); end
      endcase
    end
    q.push_back(8'h20);
    q.push_back(8'h50);
    return q;
  endfunction

  // Feeds the command FIFO with random gaps, then waits for the encoder to go quiet.
  task automatic run_cmd(input cq_t cmd);
    int idx   = 0;
    int quiet = 0;
    int t     = 0;
    model(cmd);
    while (t < 6000 && !(idx == cmd.size() && fifo.size() == 0 && quiet >= 4)) begin
      @(negedge i_clk);
      t++;
      if (o_ren) begin
        check("ren_legal", int'(fifo.size() > 0 && !o_busy), 1);
        if (fifo.size() > 0) i_rdata = fifo.pop_front();
      end
      if (idx < cmd.size() && $urandom_range(0, 2) != 0) begin
        fifo.push_back(cmd[idx]);
        idx++;
      end
      i_empty = (fifo.size() == 0);
      if (!o_busy && !o_ren && fifo.size() == 0) quiet++;
      else                                       quiet = 0;
    end
    check("cmd_done_in_budget", int'(t < 6000), 1);
    check("events_left", exp_ev.size(), 0);
    check("responses_left", exp_rsp.size(), 0);
    check("end_bus_released", int'({o_scl_oe, o_sda_oe}), 0);
    check("end_busy", int'(o_busy), 0);
  endtask

  // Monitor: bus decoder, slave model (ACKs address 0xA0 and its data) and response scoreboard.
  initial begin
    logic scl_n;
    logic sda_n;
    logic ack;
    scl_p = 1'b1; sda_p = 1'b1; bitcnt = 0; shv = 8'h00; first_b = 1'b0; addr_ok = 1'b0;
    slave_pull = 1'b0; scl_edges = 0; n_wen = 0; cyc = 0; last_rise = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      scl_n = ~o_scl_oe;
      sda_n = i_i2c_sda;
      if (i_res) begin
        bitcnt = 0; shv = 8'h00; first_b = 1'b0; slave_pull = 1'b0; scl_p = 1'b1; sda_p = 1'b1;
      end else begin
        if (o_wen) begin
          n_wen++;
          if (exp_rsp.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL response: got 0x%0h, expected none", o_wdata);
          end else begin
            check("response", int'(o_wdata), int'(exp_rsp.pop_front()));
          end
        end
        if (scl_p && scl_n && sda_p && !sda_n) begin
          chk_ev(EV_START);
          bitcnt  = 0;
          first_b = 1'b1;
        end else if (scl_p && scl_n && !sda_p && sda_n) begin
          chk_ev(EV_STOP);
          bitcnt  = 0;
          first_b = 1'b0;
        end
        if (!scl_p && scl_n) begin
          scl_edges++;
          if (bitcnt > 0) check("scl_period", cyc - last_rise, 4 * QD);
          last_rise = cyc;
          if (bitcnt < 8) shv = {shv[6:0], sda_n};
          bitcnt++;
          if (bitcnt == 8) chk_ev(int'(shv));
        end
        if (scl_p && !scl_n) begin
          scl_edges++;
          if (bitcnt == 8) begin
            ack = first_b ? (shv == 8'hA0) : addr_ok;
            if (first_b) addr_ok = ack;
            first_b    = 1'b0;
            slave_pull = ack;
          end else if (bitcnt >= 9) begin
            slave_pull = 1'b0;
            bitcnt     = 0;
          end
        end
        scl_p = scl_n;
        sda_p = sda_n;
      end
    end
  end

  initial begin
    cq_t cmd;
    int  sc0;
    int  w0;
    int  idx;
    int  t;
    n_cmp = 0; n_fail = 0;
    i_res = 1'b1; i_empty = 1'b1; i_rdata = 8'h00;
    repeat (3) @(negedge i_clk);
    check("rst_ren", int'(o_ren), 0);
    check("rst_scl_oe", int'(o_scl_oe), 0);
    check("rst_sda_oe", int'(o_sda_oe), 0);
    check("rst_wen", int'(o_wen), 0);
    check("rst_wdata", int'(o_wdata), 0);
    check("rst_busy", int'(o_busy), 0);
    i_res = 1'b0;

    run_cmd(s2q("S A0 12 P"));
    run_cmd(s2q("S 50 P"));
    run_cmd(s2q("S A0 S A1 P"));
    sc0 = scl_edges;
    w0  = n_wen;
    run_cmd(s2q("3x4 P 56 P"));
    check("idle_scl_edges", scl_edges - sc0, 0);
    check("idle_wen", n_wen - w0, 0);
    run_cmd(s2q("S A0 1 Z 34 P"));

    // Reset while bit 3 of the address byte is on the bus.
    exp_ev.push_back(EV_START);
    cmd = s2q("SA0");
    idx = 0;
    t   = 0;
    while (!(bitcnt == 3 && o_scl_oe == 1'b1) && t < 3000) begin
      @(negedge i_clk);
      t++;
      if (o_ren && fifo.size() > 0) i_rdata = fifo.pop_front();
      if (idx < cmd.size()) begin
        fifo.push_back(cmd[idx]);
        idx++;
      end
      i_empty = (fifo.size() == 0);
    end
    check("reach_bit3", int'(t < 3000), 1);
    check("bit3_sda_driven", int'(o_sda_oe), 1);
    i_res = 1'b1;
    #1;
    check("midrst_scl_oe", int'(o_scl_oe), 0);
    check("midrst_sda_oe", int'(o_sda_oe), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_wen", int'(o_wen), 0);
    repeat (3) @(negedge i_clk);
    fifo.delete();
    exp_ev.delete();
    exp_rsp.delete();
    i_empty = 1'b1;
    i_res   = 1'b0;
    run_cmd(s2q("S A0 P"));

    for (int r = 0; r < 12; r++) run_cmd(rnd_cmd());

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_encoder.md
I2C_ENCODER -- requirements
Module: i2c_encoder

Interface
REQ-001 SHALL have parameter P_QTR_DIV, default 60, giving i_clk cycles per SCL quarter-period (24 MHz -> 100 kHz).
REQ-002 SHALL have port i_clk, input, 1, the only clock; all logic is on its rising edge.
REQ-003 SHALL have port i_res, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_empty, input, 1, command FIFO empty flag.
REQ-005 SHALL have port o_ren, output, 1, command FIFO read strobe.
REQ-006 SHALL have port i_rdata, input, 8, ASCII command character, valid on the cycle after o_ren.
REQ-007 SHALL have port i_i2c_sda, input, 1, SDA bus level, passed through a 2-FF synchronizer before use.
REQ-008 SHALL have port o_scl_oe, output, 1, drives SCL low when 1 and releases it when 0 (open-drain).
REQ-009 SHALL have port o_sda_oe, output, 1, drives SDA low when 1 and releases it when 0 (open-drain).
REQ-010 SHALL have port o_wen, output, 1, one-cycle response write strobe.
REQ-011 SHALL have port o_wdata, output, 8, ASCII response character.
REQ-012 SHALL have port o_busy, output, 1, high whenever the FSM is outside IDLE/FETCH.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DECODE, START, RSTART, BIT, ACK, STOP.
REQ-014 SHALL time bus phases with a quarter counter 0..P_QTR_DIV-1; each quarter lasts exactly P_QTR_DIV cycles.
REQ-015 SHALL, in IDLE/FETCH with i_empty=0, pulse o_ren for one cycle, then decode i_rdata in the next cycle (DECODE).
REQ-016 SHALL never pulse o_ren while i_empty=1 or while in START/RSTART/BIT/ACK/STOP.
REQ-017 SHALL treat 'S' (0x53) as START: bus idle -> START; bus active -> RSTART (repeated start).
REQ-018 SHALL, in START, sequence SDA-release/SCL-release, then SDA low, then SDA low, then SCL low (four quarters), leaving the bus active.
REQ-019 SHALL, in RSTART, sequence SCL low/SDA released, then SCL released, then SDA low, then SCL low.
REQ-020 SHALL treat '0'-'9', 'A'-'F', and 'a'-'f' as hex nibbles: the first nibble is stored as the high nibble, and the second completes the byte and enters BIT.
REQ-021 SHALL, in BIT, send 8 bits MSB first, using per-bit quarters: SCL low + set SDA, SCL low, SCL released, SCL released.
REQ-022 SHALL, in ACK, release SDA for a 9th clock, sample synchronized SDA at the end of the third quarter, and return SCL low.
REQ-023 SHALL, after ACK, pulse o_wen one cycle with o_wdata=0x41 ('A') if the sampled SDA is 0, or 0x4E ('N') if it is 1; the consumer always accepts.
REQ-024 SHALL treat 'P' (0x50) as STOP: SCL low/SDA low, then SCL released, then SDA released, then hold one quarter; the bus then becomes idle.
REQ-025 SHALL ignore space, CR, and LF without disturbing a pending nibble.
REQ-026 SHALL ignore any other character and discard a pending nibble.
REQ-027 SHALL discard a pending nibble when 'S' or 'P' arrives.
REQ-028 SHALL discard a completed byte while the bus is idle, with no bus activity and no response.
REQ-029 SHALL ignore 'P' while the bus is idle.
REQ-030 SHALL NOT support clock stretching or arbitration; the SCL level is not monitored.

Reset
REQ-031 SHALL, on i_res=1, immediately force o_ren=0, o_scl_oe=0, o_sda_oe=0, o_wen=0, o_wdata=0x00, o_busy=0, FSM=IDLE, bus-idle flag=1, pending nibble cleared, quarter counter=0.
REQ-032 SHALL, on reset mid-transaction, release both lines at once, with no STOP generated.

Verification (P_QTR_DIV=4, model slave ACKs address 0xA0 only)
REQ-033 SHALL verify: FIFO "S A0 12 P" -> START, 0xA0 MSB-first, ACK, 0x12, ACK, STOP; o_wdata 0x41, 0x41; each SCL period 16 cycles.
REQ-034 SHALL verify: "S 50 P" -> o_wdata 0x4E; STOP still generated; o_busy low after STOP.
REQ-035 SHALL verify: "S A0 S A1 P" -> repeated-start waveform between bytes; two responses 0x41, 0x4E.
REQ-036 SHALL verify: "3x4 P" before any 'S' -> byte discarded, no SCL edges, no o_wen.
REQ-037 SHALL verify: "S A0 1 Z 34 P" -> bytes 0xA0, 0x34 only (the '1' is discarded by 'Z').
REQ-038 SHALL verify: i_res asserted during bit 3 of a byte -> o_scl_oe=o_sda_oe=0 the same cycle; after release, "S A0 P" completes normally.
